// File: rtl/driver_cmd_issuer.sv
// In-order command issuer for the add-accelerator driver. It buffers host commands
// in a FIFO, issues them to the driver and returns each compute result to the host.
module driver_cmd_issuer #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int RES_LAT    = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] cmd_opcode,
   input  logic [DW-1:0] cmd_id,
   input  logic [DW-1:0] cmd_in,
   input  logic [DW-1:0] cmd_addr,
   output logic [DW-1:0] drv_opcode,
   output logic [DW-1:0] drv_id,
   output logic [DW-1:0] drv_in,
   output logic [DW-1:0] drv_addr,
   input  logic [DW-1:0] drv_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [DW-1:0] res_id,
   output logic          busy,
   output logic          err_bad_op
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic [4*DW-1:0] fifo_mem [FIFO_DEPTH];
   logic [4*DW-1:0] head;
   logic [DW-1:0]   head_f [4];
   logic [DW-1:0]   drv_opcode_reg, drv_id_reg, drv_in_reg, drv_addr_reg;
   logic [DW-1:0]   res_data_reg, res_id_reg;
   logic            res_valid_reg, err_reg;
   logic            full, empty, push, pop;
   logic            issue, capture, res_clear, bad_op;

   assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign empty = (count_reg == '0);
   assign push  = cmd_valid && !full;
   assign pop   = (state_reg == IDLE) && !empty;

   // Entry layout, MSB first: opcode, id, in, addr.
   assign head = fifo_mem[rd_ptr_reg];
   for (genvar gi = 0; gi < 4; gi++) begin : g_head
      assign head_f[gi] = head[gi*DW +: DW];
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {cmd_opcode, cmd_id, cmd_in, cmd_addr};
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      issue      = 1'b0;
      capture    = 1'b0;
      res_clear  = 1'b0;
      bad_op     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               if (head_f[3] == DW'(1)) begin
                  issue = 1'b1;
               end else if (head_f[3] == DW'(2)) begin
                  issue      = 1'b1;
                  cnt_next   = CW'(RES_LAT);
                  state_next = WAIT;
               end else if (head_f[3] != '0) begin
                  bad_op = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               res_clear  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         drv_opcode_reg <= '0;
         drv_id_reg     <= '0;
         drv_in_reg     <= '0;
         drv_addr_reg   <= '0;
         res_valid_reg  <= 1'b0;
         res_data_reg   <= '0;
         res_id_reg     <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         drv_opcode_reg <= issue ? head_f[3] : '0;
         if (issue) begin
            drv_id_reg   <= head_f[2];
            drv_in_reg   <= head_f[1];
            drv_addr_reg <= head_f[0];
         end
         // drv_id still holds the compute's id throughout WAIT.
         if (capture) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= drv_out;
            res_id_reg    <= drv_id_reg;
         end else if (res_clear) begin
            res_valid_reg <= 1'b0;
         end
         if (bad_op) err_reg <= 1'b1;
      end
   end

   assign cmd_ready  = !full;
   assign drv_opcode = drv_opcode_reg;
   assign drv_id     = drv_id_reg;
   assign drv_in     = drv_in_reg;
   assign drv_addr   = drv_addr_reg;
   assign res_valid  = res_valid_reg;
   assign res_data   = res_data_reg;
   assign res_id     = res_id_reg;
   assign busy       = !empty || (state_reg != IDLE) || (drv_opcode_reg != '0);
   assign err_bad_op = err_reg;
endmodule

// File: tb/tb_driver_cmd_issuer.sv
// Bench for driver_cmd_issuer: directed scenarios plus random commands checked
// against a queue-based model of issue order and accumulated compute results.
module tb_driver_cmd_issuer;
   typedef struct packed {
      logic [31:0] op;
      logic [31:0] id;
      logic [31:0] inn;
      logic [31:0] addr;
   } cmd_t;
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] id;
   } res_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, res_valid, res_ready, busy, err_bad_op;
   logic [31:0] cmd_opcode, cmd_id, cmd_in, cmd_addr;
   logic [31:0] drv_opcode, drv_id, drv_in, drv_addr, drv_out, res_data, res_id;

   logic        s_cmd_valid, s_cmd_ready, s_res_valid, s_res_ready, s_busy, s_err;
   logic [31:0] s_cmd_opcode, s_cmd_id, s_cmd_in, s_cmd_addr;
   logic [31:0] s_drv_opcode, s_drv_id, s_drv_in, s_drv_addr, s_drv_out, s_res_data, s_res_id;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_res_hi = 0;
   int   issue_cyc[$];
   cmd_t exp_issue[$];
   res_t exp_res[$];
   logic [31:0] m_acc = 0;
   logic [31:0] d_acc = 0;
   logic        exp_err = 1'b0;
   logic        rand_rdy = 1'b0;
   logic [31:0] last_data = 0, last_id = 0;
   logic        have_prev = 1'b0, prev_hold = 1'b0;
   logic [31:0] prev_data = 0, prev_id = 0;

   always #5 clock = ~clock;

   driver_cmd_issuer #(.DW(32), .FIFO_DEPTH(4), .RES_LAT(1)) u_dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_id(cmd_id), .cmd_in(cmd_in), .cmd_addr(cmd_addr),
      .drv_opcode(drv_opcode), .drv_id(drv_id), .drv_in(drv_in), .drv_addr(drv_addr),
      .drv_out(drv_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .busy(busy), .err_bad_op(err_bad_op));

   driver_cmd_issuer #(.DW(32), .FIFO_DEPTH(4), .RES_LAT(3)) u_dut3 (
      .clock(clock), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
      .cmd_opcode(s_cmd_opcode), .cmd_id(s_cmd_id), .cmd_in(s_cmd_in), .cmd_addr(s_cmd_addr),
      .drv_opcode(s_drv_opcode), .drv_id(s_drv_id), .drv_in(s_drv_in), .drv_addr(s_drv_addr),
      .drv_out(s_drv_out), .res_valid(s_res_valid), .res_ready(s_res_ready),
      .res_data(s_res_data), .res_id(s_res_id), .busy(s_busy), .err_bad_op(s_err));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Accelerator stand-in: accumulates in+addr of each WRITE, returns the sum one cycle after a COMPUTE.
   always @(posedge clock) begin
      #1;
      if (reset) d_acc = 0;
      else if (drv_opcode == 1) d_acc = d_acc + drv_in + drv_addr;
      else if (drv_opcode == 2) begin
         drv_out = d_acc;
         d_acc   = 0;
      end
   end

   task automatic model_push(input cmd_t c);
      res_t r;
      if (c.op == 1) begin
         m_acc = m_acc + c.inn + c.addr;
         exp_issue.push_back(c);
      end else if (c.op == 2) begin
         exp_issue.push_back(c);
         r.data = m_acc;
         r.id   = c.id;
         exp_res.push_back(r);
         m_acc = 0;
      end else if (c.op != 0) begin
         exp_err = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_issue.delete();
      exp_res.delete();
      m_acc   = 0;
      exp_err = 1'b0;
   endtask

   // Monitor: every cycle with drv_opcode!=0 is one issue; every handshake is one result.
   always @(negedge clock) begin
      cmd_t c;
      res_t r;
      if (reset) begin
         have_prev = 1'b0;
      end else begin
         cyc++;
         if (drv_opcode != 0) begin
            issue_cyc.push_back(cyc);
            if (exp_issue.size() == 0) chk("unexpected_issue", drv_opcode, 0);
            else begin
               c = exp_issue.pop_front();
               chk("issue", {drv_opcode, drv_id, drv_in, drv_addr}, c);
            end
         end
         if (have_prev && prev_hold)
            chk("res_stable", {res_valid, res_data, res_id}, {1'b1, prev_data, prev_id});
         if (res_valid) n_res_hi++;
         if (res_valid && res_ready) begin
            $display("result id=%0d data=%0d", res_id, res_data);
            last_data = res_data;
            last_id   = res_id;
            if (exp_res.size() == 0) chk("unexpected_result", res_valid, 0);
            else begin
               r = exp_res.pop_front();
               chk("result", {res_data, res_id}, r);
            end
         end
         have_prev = 1'b1;
         prev_hold = res_valid && !res_ready;
         prev_data = res_data;
         prev_id   = res_id;
      end
   end

   task automatic push(input logic [31:0] op, id, inn, addr);
      int   t = 0;
      cmd_t c;
      c.op = op; c.id = id; c.inn = inn; c.addr = addr;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_id = id; cmd_in = inn; cmd_addr = addr;
      while (!cmd_ready && t < 200) begin
         @(posedge clock); #1;
         t++;
         if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
      end
      if (!cmd_ready) chk("push_timeout", cmd_ready, 1);
      else begin
         @(posedge clock);
         model_push(c);
         $display("push op=%0d id=%0d in=%0d addr=%0d", op, id, inn, addr);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while ((busy || res_valid) && t < 300) begin
         @(posedge clock); #1;
         t++;
      end
      chk(tag, busy || res_valid, 0);
   endtask

   task automatic wait_res(input string tag);
      int t = 0;
      while (!res_valid && t < 100) begin
         @(posedge clock); #1;
         t++;
      end
      chk(tag, res_valid, 1);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n0;
      int          nq;
      logic [31:0] v [4];
      logic [31:0] op;
      reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
      cmd_opcode = 0; cmd_id = 0; cmd_in = 0; cmd_addr = 0; drv_out = 0;
      s_cmd_valid = 1'b0; s_res_ready = 1'b0;
      s_cmd_opcode = 0; s_cmd_id = 0; s_cmd_in = 0; s_cmd_addr = 0; s_drv_out = 0;

      // 1: reset held 40 ns
      #20;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_drv", {drv_opcode, drv_id, drv_in, drv_addr}, 0);
      chk("rst_res", {res_valid, res_data, res_id}, 0);
      chk("rst_busy_err", {busy, err_bad_op}, 0);
      #20;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         chk("post_rst_idle", {drv_opcode, busy}, 0);
      end

      // 2: two writes and a compute, back to back
      n0 = n_res_hi;
      push(1, 1, 0, 5);
      push(1, 2, 0, 6);
      push(2, 3, 0, 0);
      wait_idle("t2_drain");
      nq = issue_cyc.size();
      chk("t2_issue_gap1", issue_cyc[nq-2] - issue_cyc[nq-3], 1);
      chk("t2_issue_gap2", issue_cyc[nq-1] - issue_cyc[nq-3], 2);
      chk("t2_res_pulse", n_res_hi - n0, 1);
      chk("t2_res", {last_data, last_id}, {32'd11, 32'd3});

      // 3: host stalls the result, FIFO fills, then drains in order
      res_ready = 1'b0;
      push(1, 5, 0, 7);
      push(2, 6, 0, 0);
      wait_res("t3_res_arrives");
      for (int i = 0; i < 6; i++) begin
         cycles(1);
         chk("t3_hold", {drv_opcode, res_valid, res_data, res_id}, {32'd0, 1'b1, 32'd7, 32'd6});
      end
      for (int i = 0; i < 4; i++) push(1, 20 + i, i, 1);
      chk("t3_full", {cmd_ready, busy}, {1'b0, 1'b1});
      res_ready = 1'b1;
      wait_idle("t3_drain");
      chk("t3_all_issued", exp_issue.size(), 0);

      // 4: illegal opcode dropped, sticky error
      push(7, 30, 0, 0);
      push(1, 31, 0, 9);
      wait_idle("t4_drain");
      chk("t4_err", err_bad_op, 1);
      cycles(5);
      chk("t4_err_sticky", err_bad_op, 1);
      chk("t4_all_issued", exp_issue.size(), 0);

      // 5: reset while waiting on a compute with two commands queued
      res_ready = 1'b0;
      push(2, 11, 0, 0);
      wait_res("t5_first_res");
      push(2, 12, 0, 0);
      push(1, 13, 1, 1);
      push(1, 14, 2, 2);
      res_ready = 1'b1;
      cycles(1);
      res_ready = 1'b0;
      cycles(1);
      chk("t5_in_wait", drv_opcode, 2);
      reset = 1'b1;
      model_reset();
      #1;
      chk("t5_rst_now", {busy, cmd_ready, res_valid, drv_opcode}, {1'b0, 1'b1, 1'b0, 32'd0});
      cycles(2);
      reset = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycles(1);
         chk("t5_quiet", {res_valid, drv_opcode, busy, err_bad_op}, 0);
      end

      // random commands against the model
      rand_rdy = 1'b1;
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 19))
            0, 1:    op = 0;
            2:       op = 3 + $urandom_range(0, 20);
            3, 4, 5, 6, 7: op = 2;
            default: op = 1;
         endcase
         push(op, $urandom, $urandom_range(0, 1000), $urandom_range(0, 1000));
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            res_ready = ($urandom_range(0, 3) != 0);
            cycles(1);
         end
      end
      rand_rdy = 1'b0;
      res_ready = 1'b1;
      wait_idle("rnd_drain");
      chk("rnd_issues_left", exp_issue.size(), 0);
      chk("rnd_results_left", exp_res.size(), 0);
      chk("rnd_err", err_bad_op, exp_err);

      // 6: RES_LAT=3 captures the value present at the third edge after launch
      for (int k = 0; k < 4; k++) begin
         v[k] = $urandom;
         v[k][1:0] = k[1:0];
      end
      s_cmd_valid = 1'b1; s_cmd_opcode = 1; s_cmd_id = 40; s_cmd_in = 1; s_cmd_addr = 2;
      cycles(1);
      s_cmd_opcode = 2; s_cmd_id = 41; s_cmd_in = 0; s_cmd_addr = 0;
      cycles(1);
      s_cmd_valid = 1'b0;
      chk("t6_write", s_drv_opcode, 1);
      cycles(1);
      chk("t6_launch", {s_drv_opcode, s_drv_id}, {32'd2, 32'd41});
      s_drv_out = v[0];
      cycles(1);
      chk("t6_edge1", {s_drv_opcode, s_res_valid}, 0);
      s_drv_out = v[1];
      cycles(1);
      chk("t6_edge2", {s_drv_opcode, s_res_valid}, 0);
      s_drv_out = v[2];
      cycles(1);
      chk("t6_edge3", {s_res_valid, s_res_data, s_res_id}, {1'b1, v[2], 32'd41});
      s_drv_out = v[3];
      cycles(1);
      chk("t6_held", {s_res_valid, s_res_data}, {1'b1, v[2]});
      s_res_ready = 1'b1;
      cycles(1);
      chk("t6_done", {s_res_valid, s_busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
